// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared widths, reset/increment defaults and fetch FSM encoding
package fetch_pc_ctrl_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] DEF_RESET_PC = 32'hBFC0_0000;
   localparam logic [XLEN-1:0] DEF_PC_INC = 32'd4;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} fetch_state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: architectural PC with reset-load, aligned redirect-load, increment and misalign pulse
module fetch_pc_reg
   import fetch_pc_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [XLEN-1:0] PC_INC = DEF_PC_INC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_inc,
   output logic [XLEN-1:0] o_pc,
   output logic            o_misalign
);
   logic [XLEN-1:0] r_pc;
   logic            r_misalign;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
         r_misalign <= 1'b0;
      end else begin
         r_pc <= i_redirect ? {i_redirect_pc[XLEN-1:2], 2'b00} : i_inc ? r_pc + PC_INC : r_pc;
         r_misalign <= i_redirect & |i_redirect_pc[1:0];
      end
   end
   assign o_pc = r_pc;
   assign o_misalign = r_misalign;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch sequencer with one outstanding imem request, redirect kill and stall hold
module fetch_pc_ctrl
   import fetch_pc_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [XLEN-1:0] PC_INC = DEF_PC_INC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_stall,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic            o_if_valid,
   output logic [XLEN-1:0] o_if_pc,
   output logic [XLEN-1:0] o_if_instr,
   output logic            o_misalign
);
   fetch_state_t    r_state, w_state_n;
   logic            r_kill, w_kill_n, w_capture, w_inc;
   logic [XLEN-1:0] r_if_pc, r_if_instr, w_pc;
   fetch_pc_reg #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) u_pc (
      .clk           (clk),
      .rst           (rst),
      .i_redirect    (i_redirect_valid),
      .i_redirect_pc (i_redirect_pc),
      .i_inc         (w_inc),
      .o_pc          (w_pc),
      .o_misalign    (o_misalign)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_kill <= 1'b0;
         r_if_pc <= '0;
         r_if_instr <= '0;
      end else begin
         r_state <= w_state_n;
         r_kill <= w_kill_n;
         if (w_capture) begin
            r_if_pc <= w_pc;
            r_if_instr <= i_imem_rdata;
         end
      end
   end
   // A redirect while a granted request is in flight marks its response for discard
   always_comb begin
      w_state_n = r_state;
      w_kill_n = r_kill;
      w_capture = 1'b0;
      w_inc = 1'b0;
      case (r_state)
         IDLE: w_state_n = REQ;
         REQ: begin
            w_state_n = i_imem_gnt ? WAIT : REQ;
            w_kill_n = i_imem_gnt & i_redirect_valid;
         end
         WAIT: begin
            w_state_n = !i_imem_rvalid ? WAIT : (r_kill | i_redirect_valid) ? REQ : HOLD;
            w_capture = i_imem_rvalid & !r_kill & !i_redirect_valid;
            w_kill_n = !i_imem_rvalid & (r_kill | i_redirect_valid);
         end
         HOLD: begin
            w_state_n = (i_redirect_valid | !i_stall) ? REQ : HOLD;
            w_inc = !i_redirect_valid & !i_stall;
         end
      endcase
   end
   assign o_imem_req = r_state == REQ;
   assign o_imem_addr = w_pc;
   assign o_if_valid = r_state == HOLD;
   assign o_if_pc = r_if_pc;
   assign o_if_instr = r_if_instr;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed checks of fetch sequencing, stall, redirect kill, misalign, reset and wrap
module tb_fetch_pc_ctrl;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redir = 1'b0, gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] redir_pc = '0, rdata = '0;
   logic        imem_req, if_valid, misalign;
   logic [31:0] imem_addr, if_pc, if_instr;
   int          checks = 0, failures = 0;
   always #5 clk = ~clk;
   fetch_pc_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .i_stall          (stall),
      .i_redirect_valid (redir),
      .i_redirect_pc    (redir_pc),
      .o_imem_req       (imem_req),
      .o_imem_addr      (imem_addr),
      .i_imem_gnt       (gnt),
      .i_imem_rvalid    (rvalid),
      .i_imem_rdata     (rdata),
      .o_if_valid       (if_valid),
      .o_if_pc          (if_pc),
      .o_if_instr       (if_instr),
      .o_misalign       (misalign)
   );
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic fetch_one(input logic [31:0] pc, input logic [31:0] instr);
      chk("req_before_fetch", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, pc);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      chk("req_in_wait", {31'd0, imem_req}, 32'd0);
      chk("valid_in_wait", {31'd0, if_valid}, 32'd0);
      rvalid = 1'b1;
      rdata = instr;
      step();
      rvalid = 1'b0;
      chk("if_valid_hold", {31'd0, if_valid}, 32'd1);
      chk("if_pc", if_pc, pc);
      chk("if_instr", if_instr, instr);
   endtask
   initial begin
      @(negedge clk);
      step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_addr", imem_addr, 32'hBFC0_0000);
      rst = 1'b0;
      step();
      fetch_one(32'hBFC0_0000, 32'h0000_0001);
      step();
      chk("consumed_valid", {31'd0, if_valid}, 32'd0);
      fetch_one(32'hBFC0_0004, 32'h0000_0002);
      step();
      fetch_one(32'hBFC0_0008, 32'h2408_0001);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", {31'd0, if_valid}, 32'd1);
         chk("stall_pc", if_pc, 32'hBFC0_0008);
         chk("stall_instr", if_instr, 32'h2408_0001);
         chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      step();
      chk("after_stall_req", {31'd0, imem_req}, 32'd1);
      chk("after_stall_addr", imem_addr, 32'hBFC0_000C);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      redir = 1'b1;
      redir_pc = 32'h8000_0040;
      step();
      redir = 1'b0;
      chk("wait_redir_addr", imem_addr, 32'h8000_0040);
      chk("wait_redir_req", {31'd0, imem_req}, 32'd0);
      rvalid = 1'b1;
      rdata = 32'hDEAD_BEEF;
      step();
      rvalid = 1'b0;
      chk("killed_valid", {31'd0, if_valid}, 32'd0);
      chk("killed_req", {31'd0, imem_req}, 32'd1);
      chk("killed_next_addr", imem_addr, 32'h8000_0040);
      gnt = 1'b1;
      redir = 1'b1;
      redir_pc = 32'h0000_0100;
      step();
      gnt = 1'b0;
      redir = 1'b0;
      chk("gnt_redir_req", {31'd0, imem_req}, 32'd0);
      rvalid = 1'b1;
      rdata = 32'hBAD0_BAD0;
      step();
      rvalid = 1'b0;
      chk("gnt_redir_discard", {31'd0, if_valid}, 32'd0);
      fetch_one(32'h0000_0100, 32'h1111_1111);
      stall = 1'b1;
      redir = 1'b1;
      redir_pc = 32'h0000_0203;
      step();
      redir = 1'b0;
      chk("hold_redir_valid", {31'd0, if_valid}, 32'd0);
      chk("misalign_pulse", {31'd0, misalign}, 32'd1);
      chk("hold_redir_addr", imem_addr, 32'h0000_0200);
      chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
      step();
      chk("misalign_once", {31'd0, misalign}, 32'd0);
      chk("req_waits_gnt", {31'd0, imem_req}, 32'd1);
      stall = 1'b0;
      redir = 1'b1;
      redir_pc = 32'h0000_1000;
      step();
      redir = 1'b0;
      chk("req_redir_addr", imem_addr, 32'h0000_1000);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      chk("midrst_valid", {31'd0, if_valid}, 32'd0);
      step();
      chk("midrst_req_again", {31'd0, imem_req}, 32'd1);
      chk("midrst_addr", imem_addr, 32'hBFC0_0000);
      redir = 1'b1;
      redir_pc = 32'hFFFF_FFFC;
      step();
      redir = 1'b0;
      chk("aligned_no_misalign", {31'd0, misalign}, 32'd0);
      fetch_one(32'hFFFF_FFFC, 32'h2222_2222);
      step();
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      chk("wrap_req", {31'd0, imem_req}, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Fetch-stage sequencer. It owns the architectural PC register and sequences instruction fetches from instruction memory through a request/grant/response handshake. It applies branch/jump redirects produced by the next-PC logic in EX, and honours stalls from the hazard unit. It delivers {pc, instr} pairs to the IF/ID pipeline register with at most one memory request outstanding.

Parameters:
RESET_PC, 32'hBFC0_0000, PC value loaded on reset
PC_INC, 32'd4, sequential PC increment

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  IF/ID cannot accept; held instruction must not be consumed
redirect_valid  in  1  one-cycle pulse: branch taken or jump resolved
redirect_pc  in  32  redirect target, from next-PC logic
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  response data valid, exactly one per granted request
imem_rdata  in  32  instruction word
if_valid  out  1  if_pc/if_instr hold a valid instruction
if_pc  out  32  PC of the delivered instruction
if_instr  out  32  delivered instruction word
misalign  out  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, pc=RESET_PC, kill=0, imem_req=0, if_valid=0, if_pc=0, if_instr=0, misalign=0. Reset mid-transaction abandons it. imem shares rst, so no stale rvalid follows.
- States:
  IDLE → REQ after one cycle.
  REQ: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT.
  WAIT: imem_req=0; wait for imem_rvalid.
  HOLD: if_valid=1; wait for consumption.
- imem_addr is driven combinationally from pc. The request is registered state, with no combinational path from imem_gnt to imem_req.
- WAIT with rvalid and kill=0: capture if_pc=pc and if_instr=imem_rdata, set if_valid=1 on the next cycle, go to HOLD.
- WAIT with rvalid and kill=1: discard the data, clear kill, go to REQ (pc already holds the redirect target).
- HOLD with stall=0: the instruction is consumed at this edge. Set pc=pc+PC_INC (mod 2^32, wrap permitted), clear if_valid, go to REQ.
- HOLD with stall=1: hold all outputs stable.
- Redirect (redirect_valid=1), any state except IDLE/reset:
  - pc ← {redirect_pc[31:2],2'b00}. If redirect_pc[1:0]≠0, misalign=1 for the next cycle.
  - REQ, no gnt in same cycle: the request is not yet accepted, so imem_addr switches to the new pc next cycle. Stay in REQ.
  - REQ with gnt in same cycle: the old-address request was accepted. Set kill=1, go to WAIT.
  - WAIT: set kill=1. If rvalid arrives in the same cycle, discard it and go directly to REQ.
  - HOLD: drop the held instruction (if_valid←0) regardless of stall, go to REQ.
- Priority: rst > redirect > stall/consumption > sequential advance.
- redirect_valid during IDLE: pc ← target. The first fetch uses the redirect target.
- Throughput: one instruction per 3 cycles minimum (REQ+gnt, WAIT+rvalid, HOLD consume). No fetch while HOLD.
- Latency: redirect to imem_req at the new address is ≤1 cycle from REQ/HOLD, or rvalid+1 cycle from WAIT.
- Invariant: at most one granted-but-unanswered request; kill only set while one is outstanding.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3), RESET_PC default, PC_INC, instruction/address width 32.
- Natural sub-module: fetch_pc_reg, the PC register with reset-load, redirect-load, increment-on-consume, and alignment masking. The FSM and handshake stay in the top.

Test Plan:
- Reset then free-running fetch, gnt same cycle as req, rvalid 1 cycle later, stall=0 → imem_addr sequence BFC00000, BFC00004, BFC00008. if_valid high 1 cycle per instruction, if_pc matches.
- Stall 3 cycles while in HOLD with instr 0x2408_0001 → if_valid/if_pc/if_instr frozen for 3 cycles. Next imem_req only after stall drops.
- Redirect to 0x8000_0040 in WAIT, rvalid 2 cycles later with 0xDEADBEEF → if_valid never asserts for it. Next imem_addr=0x8000_0040.
- Redirect to 0x0000_0100 coincident with imem_gnt in REQ → old response discarded. Next request addr 0x100, delivered if_pc=0x100.
- Redirect to 0x0000_0203 while HOLD with stall=1 → if_valid drops next cycle, misalign pulses once, imem_addr=0x0000_0200.
- rst asserted in WAIT at pc=0x1000 → next cycle imem_req=0, if_valid=0. Two cycles later imem_req=1, imem_addr=BFC00000. pc=0xFFFFFFFC consumed wraps to 0x00000000.
